// File: rtl/mem_read_sequencer_if.sv
// Memory-side bus between the read sequencer (master) and the cache/memory (slave).
// WORD_LENGTH defaults to 32 when the build does not provide it.
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

// Handshake: the master holds address for a whole cycle; hit acts as the
// acceptance strobe, and mem_out is valid only in a cycle where hit is high.
interface mem_read_sequencer_if;
    logic [14:0]             address;
    logic                    hit;
    logic [`WORD_LENGTH-1:0] mem_out;

    modport master (output address, input hit, input mem_out);
    modport slave  (input address, output hit, output mem_out);
endinterface

// File: rtl/mem_read_sequencer.sv
// Walks a run of word addresses, retries misses, tallies first-try hits/misses and a checksum.
// Optional macro MEM_SEQ_STRIDE_EN adds a stride_i input sampled at start (default increment 1).
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

module mem_read_sequencer #(
    parameter int COUNT_W     = 16,
    parameter int REFILL_WAIT = 0,
    parameter int MAX_RETRY   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [14:0]             base_addr_i,
    input  logic [COUNT_W-1:0]      count_i,
`ifdef MEM_SEQ_STRIDE_EN
    input  logic [14:0]             stride_i,
`endif
    mem_read_sequencer_if.master    mem,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [COUNT_W-1:0]      hit_count_o,
    output logic [COUNT_W-1:0]      miss_count_o,
    output logic [`WORD_LENGTH-1:0] last_data_o,
    output logic [`WORD_LENGTH-1:0] checksum_o,
    output logic [1:0]              state_o
);
    localparam int WORD_W  = `WORD_LENGTH;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int WAIT_W  = (REFILL_WAIT > 1) ? $clog2(REFILL_WAIT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [14:0]          addr_q, addr_d;
    logic [COUNT_W-1:0]   remaining_q, remaining_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic                 first_try_q, first_try_d;
    logic [COUNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [COUNT_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic [WORD_W-1:0]    last_q, last_d;
    logic [WORD_W-1:0]    csum_q, csum_d;
    logic                 err_q, err_d;
    logic [14:0]          addr_step;

`ifdef MEM_SEQ_STRIDE_EN
    logic [14:0] stride_q, stride_d;
    assign addr_step = stride_q;
`else
    assign addr_step = 15'd1;
`endif

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v, input logic en);
        return (en && (v != {COUNT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            retry_q     <= '0;
            wait_q      <= '0;
            first_try_q <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            last_q      <= '0;
            csum_q      <= '0;
            err_q       <= 1'b0;
`ifdef MEM_SEQ_STRIDE_EN
            stride_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            retry_q     <= retry_d;
            wait_q      <= wait_d;
            first_try_q <= first_try_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            last_q      <= last_d;
            csum_q      <= csum_d;
            err_q       <= err_d;
`ifdef MEM_SEQ_STRIDE_EN
            stride_q    <= stride_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        retry_d     = retry_q;
        wait_d      = wait_q;
        first_try_d = first_try_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        last_d      = last_q;
        csum_d      = csum_q;
        err_d       = err_q;
`ifdef MEM_SEQ_STRIDE_EN
        stride_d    = stride_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    hit_cnt_d  = '0;
                    miss_cnt_d = '0;
                    last_d     = '0;
                    csum_d     = '0;
                    err_d      = 1'b0;
                    if (count_i != '0) begin
                        addr_d      = base_addr_i;
                        remaining_d = count_i;
                        first_try_d = 1'b1;
                        retry_d     = '0;
`ifdef MEM_SEQ_STRIDE_EN
                        stride_d    = stride_i;
`endif
                        state_d     = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                if (mem.hit) begin
                    csum_d    = csum_q + mem.mem_out;
                    last_d    = mem.mem_out;
                    hit_cnt_d = sat_inc(hit_cnt_q, first_try_q);
                    if (remaining_q == COUNT_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        remaining_d = remaining_q - 1'b1;
                        addr_d      = addr_q + addr_step;
                        first_try_d = 1'b1;
                        retry_d     = '0;
                    end
                end else begin
                    miss_cnt_d  = sat_inc(miss_cnt_q, first_try_q);
                    first_try_d = 1'b0;
                    retry_d     = retry_q + 1'b1;
                    // This miss is the MAX_RETRY-th in a row on the same address.
                    if (retry_q == RETRY_W'(MAX_RETRY - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (REFILL_WAIT > 0) begin
                        wait_d  = WAIT_W'(REFILL_WAIT);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                wait_d = wait_q - 1'b1;
                if (wait_q <= WAIT_W'(1)) state_d = S_ISSUE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign mem.address  = addr_q;
    assign busy_o       = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done_o       = (state_q == S_DONE);
    assign err_o        = err_q;
    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
    assign last_data_o  = last_q;
    assign checksum_o   = csum_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_mem_read_sequencer.sv
// Bench: two sequencers (REFILL_WAIT 0 and 2) share stimulus; each has its own block-miss memory
// model and expected queue, checked at every done pulse against a run-level reference model.
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

module tb_mem_read_sequencer;
    localparam int CW = 16;
    localparam int WW = `WORD_LENGTH;
    localparam int MAXR = 4;

    typedef struct packed {
        logic [CW-1:0] hits;
        logic [CW-1:0] misses;
        logic [WW-1:0] csum;
        logic [WW-1:0] last;
        logic          err;
        logic [15:0]   cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [14:0] base_addr = '0;
    logic [CW-1:0] count = '0;
    logic [14:0] stride = 15'd1;

    logic          busy0, done0, err0, busy1, done1, err1;
    logic [CW-1:0] hc0, mc0, hc1, mc1;
    logic [WW-1:0] ld0, cs0, ld1, cs1;
    logic [1:0]    st0, st1;

    int n_cmp = 0;
    int n_err = 0;
    int run_id = 1;
    logic poison_on = 1'b0;
    logic [14:0] poison_addr = '0;
    int seen0 [8192];
    int seen1 [8192];
    exp_t exp_q0[$];
    exp_t exp_q1[$];

    mem_read_sequencer_if mif0();
    mem_read_sequencer_if mif1();

    mem_read_sequencer #(.COUNT_W(CW), .REFILL_WAIT(0), .MAX_RETRY(MAXR)) dut0 (
        .clk(clk), .rst(rst), .start_i(start), .base_addr_i(base_addr), .count_i(count),
`ifdef MEM_SEQ_STRIDE_EN
        .stride_i(stride),
`endif
        .mem(mif0), .busy_o(busy0), .done_o(done0), .err_o(err0),
        .hit_count_o(hc0), .miss_count_o(mc0), .last_data_o(ld0), .checksum_o(cs0), .state_o(st0)
    );

    mem_read_sequencer #(.COUNT_W(CW), .REFILL_WAIT(2), .MAX_RETRY(MAXR)) dut1 (
        .clk(clk), .rst(rst), .start_i(start), .base_addr_i(base_addr), .count_i(count),
`ifdef MEM_SEQ_STRIDE_EN
        .stride_i(stride),
`endif
        .mem(mif1), .busy_o(busy1), .done_o(done1), .err_o(err1),
        .hit_count_o(hc1), .miss_count_o(mc1), .last_data_o(ld1), .checksum_o(cs1), .state_o(st1)
    );

    always #5 clk = ~clk;

    function automatic logic [WW-1:0] data_of(input logic [14:0] a);
        return (WW'(a) * WW'(32'h0001_0193)) ^ WW'(32'h5A5A_0000);
    endfunction

    // Memory model: a 4-word block misses on its first access in a run, then hits.
    always_comb begin
        mif0.hit     = (seen0[mif0.address[14:2]] == run_id) && !(poison_on && mif0.address == poison_addr);
        mif0.mem_out = mif0.hit ? data_of(mif0.address) : ~data_of(mif0.address);
        mif1.hit     = (seen1[mif1.address[14:2]] == run_id) && !(poison_on && mif1.address == poison_addr);
        mif1.mem_out = mif1.hit ? data_of(mif1.address) : ~data_of(mif1.address);
    end

    always @(posedge clk) begin
        if (busy0) seen0[mif0.address[14:2]] <= run_id;
        if (busy1) seen1[mif1.address[14:2]] <= run_id;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Run-level reference: walk the addresses, classify each against the block rule.
    function automatic exp_t model_run(input logic [14:0] base, input logic [CW-1:0] cnt, input int rw);
        exp_t e;
        bit seen [8192];
        logic [14:0] a;
        e = '0;
        for (int i = 0; i < int'(cnt); i++) begin
            a = base + 15'(i);
            if (poison_on && a == poison_addr) begin
                e.misses = e.misses + 1'b1;
                e.cyc    = e.cyc + 16'(MAXR + (MAXR - 1) * rw);
                e.err    = 1'b1;
                break;
            end
            if (!seen[a[14:2]]) begin
                seen[a[14:2]] = 1'b1;
                e.misses = e.misses + 1'b1;
                e.cyc    = e.cyc + 16'(1 + rw);
            end else begin
                e.hits = e.hits + 1'b1;
            end
            e.cyc  = e.cyc + 16'd1;
            e.csum = e.csum + data_of(a);
            e.last = data_of(a);
        end
        return e;
    endfunction

    task automatic check_run(input int idx, input logic [CW-1:0] hc, input logic [CW-1:0] mc,
                             input logic [WW-1:0] cs, input logic [WW-1:0] ld, input logic er,
                             input int cyc);
        exp_t e;
        if (idx == 0 && exp_q0.size() == 0 || idx == 1 && exp_q1.size() == 0) begin
            chk($sformatf("dut%0d_unexpected_done", idx), 32'd1, 32'd0);
            return;
        end
        e = (idx == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk($sformatf("dut%0d_hit_count", idx), 32'(hc), 32'(e.hits));
        chk($sformatf("dut%0d_miss_count", idx), 32'(mc), 32'(e.misses));
        chk($sformatf("dut%0d_checksum", idx), 32'(cs), 32'(e.csum));
        chk($sformatf("dut%0d_last_data", idx), 32'(ld), 32'(e.last));
        chk($sformatf("dut%0d_err", idx), 32'(er), 32'(e.err));
        chk($sformatf("dut%0d_busy_cycles", idx), 32'(cyc), 32'(e.cyc));
    endtask

    int bcyc0 = 0, bcyc1 = 0;
    logic pdone0 = 1'b0, pdone1 = 1'b0;

    always @(negedge clk) begin
        if (done0) begin
            chk("dut0_done_pulse", 32'(pdone0 | busy0), 32'd0);
            check_run(0, hc0, mc0, cs0, ld0, err0, bcyc0);
            bcyc0 = 0;
        end else if (busy0) bcyc0++;
        else bcyc0 = 0;
        pdone0 = done0;
    end

    always @(negedge clk) begin
        if (done1) begin
            chk("dut1_done_pulse", 32'(pdone1 | busy1), 32'd0);
            check_run(1, hc1, mc1, cs1, ld1, err1, bcyc1);
            bcyc1 = 0;
        end else if (busy1) bcyc1++;
        else bcyc1 = 0;
        pdone1 = done1;
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_dut0_outs"}, {busy0, done0, err0, 14'(mif0.address), hc0 | mc0}, 32'd0);
        chk({tag, "_dut0_data"}, 32'(ld0 | cs0), 32'd0);
        chk({tag, "_dut1_outs"}, {busy1, done1, err1, 14'(mif1.address), hc1 | mc1}, 32'd0);
        chk({tag, "_dut1_data"}, 32'(ld1 | cs1), 32'd0);
    endtask

    task automatic run(input logic [14:0] base, input logic [CW-1:0] cnt);
        bit f0, f1;
        int c;
        run_id++;
        exp_q0.push_back(model_run(base, cnt, 0));
        exp_q1.push_back(model_run(base, cnt, 2));
        @(negedge clk);
        base_addr = base;
        count     = cnt;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (cnt == '0) chk("count0_done_latency", {done0, done1}, 2'b11);
        f0 = 1'b0;
        f1 = 1'b0;
        for (c = 0; c < 2000; c++) begin
            f0 |= done0;
            f1 |= done1;
            if (f0 && f1) break;
            // Stray starts only while both sequencers are past IDLE, so both must ignore them.
            if ((busy0 || done0) && (busy1 || done1) && $urandom_range(0, 3) == 0) begin
                start     = 1'b1;
                base_addr = 15'($urandom);
                count     = CW'($urandom_range(0, 50));
            end else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        if (!(f0 && f1)) chk("run_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        run(15'h0000, 16'd8);
        run(15'h7FFE, 16'd4);
        poison_on   = 1'b1;
        poison_addr = 15'h0010;
        run(15'h0010, 16'd3);
        run(15'h000E, 16'd5);
        poison_on = 1'b0;
        run(15'h0008, 16'd1);
        run(15'h1234, 16'd0);

        for (int i = 0; i < 20; i++) begin
            logic [14:0] b;
            logic [CW-1:0] n;
            b = 15'($urandom);
            n = CW'($urandom_range(1, 40));
            poison_on   = ($urandom_range(0, 3) == 0);
            poison_addr = b + 15'($urandom_range(0, 45));
            run(b, n);
        end
        poison_on = 1'b0;

        // Reset in the middle of a run: nothing expected from the interrupted run.
        run_id++;
        @(negedge clk);
        base_addr = 15'h0100;
        count     = 16'd30;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("midrun_reset");
        rst = 1'b0;
        @(negedge clk);
        run(15'h0200, 16'd6);

        repeat (3) @(negedge clk);
        chk("dut0_queue_drained", 32'(exp_q0.size()), 32'd0);
        chk("dut1_queue_drained", 32'(exp_q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_read_sequencer.md
Name: mem_read_sequencer

Overview:
- Requester-side initiator for the cache/main-memory hierarchy.
- Walks a programmed run of 15-bit word addresses, drives each one onto the memory's address input and samples hit and the returned word.
- On a miss, holds the address while the controller refills the cache, then retries.
- Tallies first-try hits and misses and accumulates a data checksum, for hit-rate measurement and self-checking benches.

Parameters:
- COUNT_W, 16, width of the run-length input and of the hit/miss counters.
- REFILL_WAIT, 0, extra idle cycles after a miss before re-presenting the address (0 = retry on the next cycle).
- MAX_RETRY, 4, consecutive misses on one address before the run aborts with err.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launches a run when sampled high in IDLE; ignored otherwise.
- base_addr  in  15  first word address of the run.
- count  in  COUNT_W  number of words to read.
- address  out  15  address driven to memory, registered.
- hit  in  1  memory hit flag for the current address.
- mem_out  in  `WORD_LENGTH  data word from memory, valid when hit=1.
- busy  out  1  high in ISSUE and WAIT.
- done  out  1  one-cycle pulse at end of run (normal or abort).
- err  out  1  set on abort, cleared by next accepted start or rst.
- hit_count  out  COUNT_W  first-try hits this run.
- miss_count  out  COUNT_W  first-try misses this run.
- last_data  out  `WORD_LENGTH  last word accepted.
- checksum  out  `WORD_LENGTH  sum of accepted words, modulo 2^`WORD_LENGTH.

Behaviour:
- Reset: rst=1 at a rising edge forces the following, from any state including mid-run:
  - state IDLE
  - address, hit_count, miss_count, last_data, checksum = 0
  - busy, done, err = 0
  - internal cur_addr, remaining, retry counter, first_try flag cleared
- State IDLE:
  - start=1 and count!=0: load cur_addr=base_addr, address=base_addr, remaining=count, first_try=1, retry counter=0; clear hit_count, miss_count, checksum, last_data, err; go to ISSUE.
  - start=1 and count=0: clear the same stats; go to DONE.
- State ISSUE:
  - address is stable for the whole cycle; hit and mem_out are sampled at the closing edge.
  - hit=1:
    - checksum += mem_out; last_data <= mem_out.
    - hit_count += first_try.
    - If remaining==1, go to DONE.
    - Otherwise remaining -= 1, cur_addr += stride (wraps mod 2^15, 0x7FFF+1 = 0x0000), address updates to match, first_try=1, retry counter=0, stay in ISSUE.
  - hit=0:
    - miss_count += first_try; first_try=0; retry counter += 1.
    - If retry counter reaches MAX_RETRY: err=1, go to DONE.
    - Else, if REFILL_WAIT>0: go to WAIT, loading the wait counter with REFILL_WAIT.
    - Else: stay in ISSUE with address held.
- State WAIT:
  - address held; hit and mem_out ignored.
  - Wait counter decrements; at 1, return to ISSUE.
- State DONE:
  - done=1 for exactly this cycle, busy=0; next state IDLE.
  - Stats hold until the next accepted start.
- start asserted while busy or in DONE is ignored (not queued).
- Counters saturate at all-ones rather than wrap.
- Throughput: one word per cycle on consecutive hits. Each miss costs 1+REFILL_WAIT cycles.

Optional Feature:
- Macro: MEM_SEQ_STRIDE_EN.
- Defined: an extra input port stride [14:0] is sampled at start and used as the address increment. stride=0 re-reads base_addr count times.
- Undefined: the port is absent and the increment is fixed at 1.

Test Plan:
- Bench memory model: block = 4 words on address[1:0]; first access to a block misses once, then hits.
- Sequential run, REFILL_WAIT=0: base=0x0000, count=8 -> misses at 0x0000 and 0x0004. Expect miss_count=2, hit_count=6, busy high for 10 cycles, then done for 1 cycle, err=0.
- Wrap: base=0x7FFE, count=4 -> addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001. Expect miss_count=2, checksum equal to the sum of the four model words.
- Abort, MAX_RETRY=4: model never asserts hit for 0x0010 -> exactly 4 ISSUE cycles at 0x0010, then done with err=1, miss_count=1, hit_count=0.
- REFILL_WAIT=2, base=0x0008, count=1 -> the miss cycle is followed by 2 cycles in WAIT, then a hit. Total busy 4 cycles; hit_count=0, miss_count=1.
- Edge cases:
  - count=0 -> done on the second cycle after start, busy never high, all stats 0.
  - start during a run -> no effect.
  - rst asserted mid-run -> all outputs 0 on the next cycle.
